// File: rtl/washer_pkg.sv
// Shared definitions for the washer input conditioning slice: pin indices,
// channel count and per-channel reset levels.
package washer_pkg;

  // Number of conditioned pin inputs
  localparam int NUM_IN = 6;

  // Bit positions of each pin within raw_in
  localparam int IDX_START   = 0;
  localparam int IDX_DOOR    = 1;
  localparam int IDX_FULL    = 2;
  localparam int IDX_DRAINED = 3;
  localparam int IDX_DRY     = 4;
  localparam int IDX_CANCEL  = 5;

  // Reset level of every channel. The door reads open out of reset so the
  // controller cannot start a cycle before a closed door has been seen.
  localparam logic [NUM_IN-1:0] DB_RESET_VAL = 6'b000010;

  // Rising-edge detector on a debounced level and its one-cycle-delayed copy
  function automatic logic rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage : washer_pkg

// File: rtl/debounce_chan.sv
// One conditioning channel: two-flop synchroniser followed by a counter-based
// debouncer. A new level is accepted only after it has been seen on the
// synchronised input for DB_CYCLES consecutive cycles; any reversion before
// that restarts the count from zero.
module debounce_chan #(
  parameter int   DB_CYCLES = 16,
  parameter logic RST_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db
);

  // Counter only ever needs to reach DB_CYCLES-1
  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             db_q,   db_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  // Next-state logic: shift the synchroniser, run the stability counter and
  // accept the synchronised level once the counter has reached its last value
  always_comb begin
    meta_d = raw;
    sync_d = meta_q;
    db_d   = db_q;
    cnt_d  = cnt_q;
    if (sync_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      db_d  = sync_q;
      cnt_d = '0;
    end
  end

  // State registers; synchroniser and debounced level reset to the channel's
  // reset level so no spurious change is seen right after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      db_q   <= RST_VAL;
      cnt_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign db = db_q;

endmodule : debounce_chan

// File: rtl/washer_input_cond.sv
// Washer input conditioning stage. Synchronises and debounces the six pin
// inputs and derives single-cycle start/cancel pulses for the controller.
//
// Output semantics: the six level outputs are plain registered levels that
// the controller may sample on any clock. start_pulse and cancel_pulse are
// strobes, high for exactly one clock in the cycle after the corresponding
// debounced level rises; there is no ready/acknowledge and a strobe not
// consumed on that cycle is lost. start_pulse is suppressed while the door
// reads open, and a suppressed press is never replayed: start must be
// released and pressed again.
module washer_input_cond
  import washer_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] raw_in,
  output logic              start_lvl,
  output logic              door_open,
  output logic              water_full,
  output logic              drained,
  output logic              dry_sensor,
  output logic              cancel_lvl,
  output logic              start_pulse,
  output logic              cancel_pulse
);

  logic [NUM_IN-1:0] db_vec;

  // One independent debounce channel per pin; no cross-channel priority
  for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
    debounce_chan #(
      .DB_CYCLES (DB_CYCLES),
      .RST_VAL   (DB_RESET_VAL[i])
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_in[i]),
      .db    (db_vec[i])
    );
  end

  logic start_prev_q,  start_prev_d;
  logic cancel_prev_q, cancel_prev_d;

  // Delayed copies of the debounced start/cancel levels for edge detection
  always_comb begin
    start_prev_d  = db_vec[IDX_START];
    cancel_prev_d = db_vec[IDX_CANCEL];
  end

  // Edge-detect flops; cleared on reset so a level already high when reset
  // releases still produces one pulse once it has been debounced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_prev_q  <= 1'b0;
      cancel_prev_q <= 1'b0;
    end else begin
      start_prev_q  <= start_prev_d;
      cancel_prev_q <= cancel_prev_d;
    end
  end

  assign start_lvl  = db_vec[IDX_START];
  assign door_open  = db_vec[IDX_DOOR];
  assign water_full = db_vec[IDX_FULL];
  assign drained    = db_vec[IDX_DRAINED];
  assign dry_sensor = db_vec[IDX_DRY];
  assign cancel_lvl = db_vec[IDX_CANCEL];

  // Start is gated by the door in the same cycle as the rising edge only;
  // since the edge lasts one cycle, a press with the door open is dropped
  assign start_pulse  = rise(db_vec[IDX_START], start_prev_q) & ~db_vec[IDX_DOOR];
  assign cancel_pulse = rise(db_vec[IDX_CANCEL], cancel_prev_q);

endmodule : washer_input_cond
